// File: rtl/vga_pkg.sv
// Shared raster constants (640x480@60 defaults, text-cell geometry) and a
// helper that derives an axis total from its four segment lengths.
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE  = 640;
  localparam int unsigned DEF_H_FRONT    = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BACK     = 48;
  localparam int unsigned DEF_V_VISIBLE  = 480;
  localparam int unsigned DEF_V_FRONT    = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BACK     = 33;
  localparam int unsigned DEF_CELL_W     = 8;
  localparam int unsigned DEF_CELL_H     = 16;
  localparam int unsigned DEF_FETCH_LEAD = 3;
  localparam int unsigned DEF_CNT_W      = 12;

  function automatic int unsigned axisTotal(input int unsigned visLen,
                                            input int unsigned frontLen,
                                            input int unsigned syncLen,
                                            input int unsigned backLen);
    return visLen + frontLen + syncLen + backLen;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the timing generator and its consumers: run/scroll controls
// in, raster position, sync, fetch and cell tracking out.
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned ROW_W = $clog2(DEF_CELL_H)
);
  logic             enable;
  logic [ROW_W-1:0] scrollIn;
  logic             scrollLoad;
  logic             hSync;
  logic             vSync;
  logic             hVis;
  logic             vVis;
  logic             nVis;
  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             lineStart;
  logic             frameStart;
  logic             fetch;
  logic [CNT_W-1:0] fetchCol;
  logic [ROW_W-1:0] rowInCell;
  logic [CNT_W-1:0] charRow;

  modport master (
    input  enable, scrollIn, scrollLoad,
    output hSync, vSync, hVis, vVis, nVis, hCount, vCount,
           lineStart, frameStart, fetch, fetchCol, rowInCell, charRow
  );

  modport slave (
    output enable, scrollIn, scrollLoad,
    input  hSync, vSync, hVis, vVis, nVis, hCount, vCount,
           lineStart, frameStart, fetch, fetchCol, rowInCell, charRow
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered visible and
// sync decodes, both taken from the next position so they align with count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VIS_LEN   = DEF_H_VISIBLE,
  parameter int unsigned FRONT_LEN = DEF_H_FRONT,
  parameter int unsigned SYNC_LEN  = DEF_H_SYNC,
  parameter int unsigned BACK_LEN  = DEF_H_BACK,
  parameter bit          POL       = 1'b0,
  parameter int unsigned CNT_W     = DEF_CNT_W
)(
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic             run,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] cntNext,
  output logic             wrap,
  output logic             vis,
  output logic             sync
);
  localparam int unsigned      TOTAL   = axisTotal(VIS_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VIS_LEN);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VIS_LEN + FRONT_LEN);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VIS_LEN + FRONT_LEN + SYNC_LEN - 1);

  always_comb begin
    wrap = run & inc & (count == LAST);
    if (!run || wrap) begin
      cntNext = '0;
    end else if (inc) begin
      cntNext = count + CNT_W'(1);
    end else begin
      cntNext = count;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst || !enable) begin
      count <= '0;
      vis   <= 1'b0;
      sync  <= ~POL;
    end else begin
      count <= cntNext;
      vis   <= (cntNext < VIS_END);
      sync  <= ((cntNext >= SYNC_LO) && (cntNext <= SYNC_HI)) ? POL : ~POL;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: two axis counters plus the VRAM prefetch window,
// frame-latched fine scroll and character-cell row tracking.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned CELL_W     = DEF_CELL_W,
  parameter int unsigned CELL_H     = DEF_CELL_H,
  parameter int unsigned FETCH_LEAD = DEF_FETCH_LEAD,
  parameter int unsigned CNT_W      = DEF_CNT_W
)(
  input logic              clk,
  input logic              nrst,
  vga_timing_gen_if.master bus
);
  localparam int unsigned      H_TOTAL    = axisTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned      V_TOTAL    = axisTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned      ROW_W      = $clog2(CELL_H);
  localparam int unsigned      COL_SHIFT  = $clog2(CELL_W);
  localparam logic [CNT_W:0]   FETCH_OPEN = (CNT_W+1)'(H_TOTAL - FETCH_LEAD);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] LEAD       = CNT_W'(FETCH_LEAD);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(CELL_H - 1);

  if ((H_TOTAL > (32'd1 << CNT_W)) || (V_TOTAL > (32'd1 << CNT_W))) begin : gTotalChk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
  end
  if ((CELL_W == 0) || ((CELL_W & (CELL_W - 1)) != 0) ||
      (CELL_H < 2) || ((CELL_H & (CELL_H - 1)) != 0)) begin : gCellChk
    $error("vga_timing_gen: CELL_W/CELL_H must be powers of two");
  end
  if (FETCH_LEAD >= H_FRONT + H_SYNC + H_BACK) begin : gLeadChk
    $error("vga_timing_gen: FETCH_LEAD must be shorter than horizontal blanking");
  end

  logic             run;
  logic [CNT_W-1:0] hCount, vCount, hNext, vNext;
  logic             hWrap, vWrap, hVis, vVis, hSync, vSync;
  logic [CNT_W-1:0] fetchDots, fetchLine;
  logic             fetchNext;
  logic [ROW_W-1:0] scrollShadow, scrollSrc;
  logic             lineStart, frameStart, nVis, fetch;
  logic [CNT_W-1:0] fetchCol, charRow;
  logic [ROW_W-1:0] rowInCell;

  vga_axis_counter #(
    .VIS_LEN(H_VISIBLE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK),
    .POL(HSYNC_POL), .CNT_W(CNT_W)
  ) uHAxis (
    .clk(clk), .nrst(nrst), .enable(bus.enable), .run(run), .inc(1'b1),
    .count(hCount), .cntNext(hNext), .wrap(hWrap), .vis(hVis), .sync(hSync)
  );

  vga_axis_counter #(
    .VIS_LEN(V_VISIBLE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK),
    .POL(VSYNC_POL), .CNT_W(CNT_W)
  ) uVAxis (
    .clk(clk), .nrst(nrst), .enable(bus.enable), .run(run), .inc(hWrap),
    .count(vCount), .cntNext(vNext), .wrap(vWrap), .vis(vVis), .sync(vSync)
  );

  // The window for line L opens FETCH_LEAD dots before L begins, so dots in
  // the tail of a line belong to the following line's window.
  always_comb begin
    fetchDots = '0;
    fetchLine = '0;
    if ({1'b0, hNext} >= FETCH_OPEN) begin
      fetchDots = hNext - FETCH_OPEN[CNT_W-1:0];
      fetchLine = (vNext == V_LAST) ? '0 : vNext + CNT_W'(1);
    end else begin
      fetchDots = hNext + LEAD;
      fetchLine = vNext;
    end
    fetchNext = (fetchDots < H_VIS_END) && (fetchLine < V_VIS_END);
  end

  // A load sampled on the same edge that opens the frame still counts as
  // arriving before the boundary, hence the bypass.
  assign scrollSrc = bus.scrollLoad ? bus.scrollIn : scrollShadow;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      run          <= 1'b0;
      scrollShadow <= '0;
      lineStart    <= 1'b0;
      frameStart   <= 1'b0;
      nVis         <= 1'b1;
      fetch        <= 1'b0;
      fetchCol     <= '0;
      rowInCell    <= '0;
      charRow      <= '0;
    end else begin
      run <= bus.enable;
      if (bus.scrollLoad) begin
        scrollShadow <= bus.scrollIn;
      end
      if (!bus.enable) begin
        lineStart  <= 1'b0;
        frameStart <= 1'b0;
        nVis       <= 1'b1;
        fetch      <= 1'b0;
        fetchCol   <= '0;
        rowInCell  <= '0;
        charRow    <= '0;
      end else begin
        lineStart  <= !run || hWrap;
        frameStart <= !run || vWrap;
        nVis       <= !((hNext < H_VIS_END) && (vNext < V_VIS_END));
        fetch      <= fetchNext;
        fetchCol   <= fetchNext ? (fetchDots >> COL_SHIFT) : '0;
        if (!run || vWrap) begin
          rowInCell <= scrollSrc;
          charRow   <= '0;
        end else if (hWrap && (vNext < V_VIS_END)) begin
          rowInCell <= rowInCell + ROW_W'(1);
          if (rowInCell == ROW_LAST) begin
            charRow <= charRow + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.hCount     = hCount;
  assign bus.vCount     = vCount;
  assign bus.hVis       = hVis;
  assign bus.vVis       = vVis;
  assign bus.hSync      = hSync;
  assign bus.vSync      = vSync;
  assign bus.nVis       = nVis;
  assign bus.lineStart  = lineStart;
  assign bus.frameStart = frameStart;
  assign bus.fetch      = fetch;
  assign bus.fetchCol   = fetchCol;
  assign bus.rowInCell  = rowInCell;
  assign bus.charRow    = charRow;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the text-mode display pipeline. It merges horizontal counting, vertical counting and sync decode into one block. It adds programmable sync polarity, a character-cell position tracker and a prefetch window for the readout/VRAM path. It also has a fine vertical scroll register that is written at any time and applied only at a frame boundary. It sits between the dot clock and the readout, pixgen and vga_output stages, replacing the fixed 640x480 counters.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in dots
- V_VISIBLE, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of the sync pulses
- CELL_W / CELL_H, 8 / 16, character cell size in pixels; both must be powers of two
- FETCH_LEAD, 3, dots by which the fetch window leads visible pixel 0; must be < H_FRONT+H_SYNC+H_BACK
- CNT_W, 12, counter width

Ports:
- clk  in  1  dot clock
- nrst  in  1  reset; one clock; reset is synchronous and active-low
- enable  in  1  run/hold control
- scrollIn  in  log2(CELL_H)  fine vertical scroll value
- scrollLoad  in  1  one-cycle strobe that captures scrollIn
- hSync, vSync  out  1  sync pulses at the configured polarity
- hVis, vVis  out  1  inside the horizontal / vertical visible region
- nVis  out  1  ~(hVis & vVis)
- hCount, vCount  out  CNT_W  current dot and line
- lineStart, frameStart  out  1  one-cycle pulse at hCount==0, and at hCount==0 & vCount==0
- fetch  out  1  prefetch window for the readout path
- fetchCol  out  CNT_W  character column being fetched
- rowInCell  out  log2(CELL_H)  pixel row inside the character cell
- charRow  out  CNT_W  character row index

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is formed the same way.
- hCount runs 0..H_TOTAL-1 and wraps to 0. vCount increments when hCount wraps, runs 0..V_TOTAL-1 and wraps to 0.
- hVis = hCount < H_VISIBLE. hSync is active for hCount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]. vVis and vSync use the same rules on vCount.
- Fetch window:
  - fetch is high for exactly H_VISIBLE consecutive dots, starting at line position H_TOTAL-FETCH_LEAD of the preceding line.
  - It asserts only for windows that end in a visible line. The window for visible line 0 starts in line V_TOTAL-1.
  - fetchCol = (dots since the window opened) >> log2(CELL_W). It holds 0 outside the window.
- Scroll:
  - scrollLoad writes a shadow register; the last write before a frame boundary wins.
  - The active scroll value is copied from the shadow at frameStart.
- Cell tracking:
  - At vCount==0, rowInCell = active scroll and charRow = 0.
  - On each line increment inside the visible region, rowInCell increments. When it wraps CELL_H-1→0, charRow increments.
  - Outside vVis, both hold their values; both are reloaded at the next frame.
- enable:
  - enable low holds all counters at 0. Syncs are inactive, nVis=1, and fetch and the pulses are 0.
  - When enable rises, counting restarts at (0,0), and frameStart fires on the first enabled cycle.
  - enable falling mid-frame takes effect on the next cycle.

## Timing
- All outputs are registered and mutually aligned: every output in cycle n describes the position hCount/vCount shown in cycle n.
- Reset values (nrst low at a clock edge):
  - hCount=vCount=0, charRow=0, rowInCell=0, fetchCol=0.
  - Scroll shadow and active scroll = 0.
  - hSync=~HSYNC_POL, vSync=~VSYNC_POL, hVis=vVis=0, nVis=1, fetch=0.
  - lineStart=frameStart=0.
- First cycle after reset release with enable=1: hCount=0, vCount=0, lineStart=frameStart=1, hVis=vVis=1, nVis=0.
- Reset asserted mid-frame: the position is abandoned and the next frame starts from (0,0). A pending scrollLoad is lost.
- scrollLoad in the same cycle as frameStart: the new value is not used this frame; it applies from the next frameStart.
- Counter arithmetic is unsigned at CNT_W. An elaboration assertion requires H_TOTAL and V_TOTAL ≤ 2^CNT_W.

## Structure
- Shared package vga_pkg holds the default mode constants (640x480@60 timing), the CELL_W/CELL_H defaults, and a derived-total helper function. readout and pixgen reuse these.
- One natural sub-module, vga_axis_counter. It is instantiated twice (horizontal and vertical), parametrised by visible/front/sync/back. It provides count, wrap, vis and sync decode.
- Fetch, scroll and cell logic live in the top of this block.

## Test plan
- Default parameters, enable=1 for two frames → H_TOTAL=800 and V_TOTAL=525. hSync low exactly over dots 656..751; vSync low over lines 490..491; frameStart every 420000 cycles.
- HSYNC_POL=1, VSYNC_POL=1 → sync pulses go high over the same ranges; both are low in reset.
- FETCH_LEAD=3 → fetch rises at line 524 dot 797 and lasts 640 dots. fetchCol steps 0..79 every 8 dots. No fetch window ends in lines 480..523.
- scrollLoad with 5 mid-frame, then again with 9 in the frameStart cycle → next frame starts rowInCell=5, charRow increments at line 11; the frame after starts at 9.
- enable dropped at (100,200), held for 50 cycles, then raised → outputs sit at reset values while low. Counting resumes at (0,0) with a frameStart pulse.
- nrst pulsed low for one cycle at (300,400) → next cycle all outputs hold their reset values; a full frame then follows with correct timing.
